// File: rtl/ram2149_pkg.sv
// Shared types and widths for the 2149 SRAM initiator.
package ram2149_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2,
        CLEAR = 2'd3
    } ram2149_state_t;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

endpackage

// File: rtl/ram2149_master.sv
// Byte-wide initiator for a 1Kx4 2149-style SRAM: splits each byte request
// into a low-nibble then high-nibble access and offers a whole-array fill.
// Every RAM pin comes straight from a flop; the pin flops load the values
// computed for the state being entered, so pins and state change together.
//
// Request handshake: a request transfers on a rising edge where
// req_valid & req_ready are both high; req_addr/req_we/req_wdata must be
// stable while req_valid is high and are latched at that edge. req_ready is
// low while busy, while a clear is pending and while clr_start is high.
// rsp_valid is a single-cycle pulse with no backpressure.
module ram2149_master
    import ram2149_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-2:0]    req_addr,
    input  logic [BYTE_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    output logic [BYTE_W-1:0]    rsp_rdata,
    input  logic                 clr_start,
    input  logic [NIB_W-1:0]     clr_data,
    output logic                 clr_busy,
    output logic [ADDR_W-1:0]    ram_A,
    output logic [NIB_W-1:0]     ram_Din,
    input  logic [NIB_W-1:0]     ram_Dout,
    output logic                 ram_CS_b,
    output logic                 ram_WE_b,
    output ram2149_state_t       dbg_state
);

    ram2149_state_t    state_q, state_n;
    logic [ADDR_W-2:0] addr_q;
    logic              we_q;
    logic [BYTE_W-1:0] wdata_q;
    logic [NIB_W-1:0]  lo_q;
    logic              clr_pend_q;
    logic              accept;

    // Next values for the registered pins and busy flag
    logic [ADDR_W-1:0] a_n;
    logic [NIB_W-1:0]  din_n;
    logic              cs_b_n;
    logic              we_b_n;
    logic              busy_n;

    assign req_ready = (state_q == IDLE) & ~clr_pend_q & ~clr_start;
    assign accept    = req_valid & req_ready;
    assign dbg_state = state_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // Next-state logic: a clear (new or pending) outranks a request in IDLE
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: begin
                if (clr_start || clr_pend_q) state_n = CLEAR;
                else if (req_valid)          state_n = LO;
            end
            LO:    state_n = HI;
            HI:    state_n = IDLE;
            CLEAR: if (ram_A == '1) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic: pin values for the cycle that starts at the next edge
    always_comb begin
        a_n    = ram_A;
        din_n  = ram_Din;
        cs_b_n = 1'b1;
        we_b_n = 1'b1;
        busy_n = (state_n == CLEAR);
        case (state_q)
            IDLE: begin
                if (state_n == CLEAR) begin
                    a_n    = '0;
                    din_n  = clr_data;
                    cs_b_n = 1'b0;
                    we_b_n = 1'b0;
                end else if (state_n == LO) begin
                    a_n    = {req_addr, 1'b0};
                    din_n  = req_wdata[NIB_W-1:0];
                    cs_b_n = 1'b0;
                    we_b_n = ~req_we;
                end
            end
            LO: begin
                a_n    = {addr_q, 1'b1};
                din_n  = wdata_q[BYTE_W-1:NIB_W];
                cs_b_n = 1'b0;
                we_b_n = ~we_q;
            end
            CLEAR: begin
                if (state_n == CLEAR) begin
                    a_n    = ram_A + ADDR_W'(1);
                    cs_b_n = 1'b0;
                    we_b_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Pin and busy registers; reset forces the pins idle immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_A    <= '0;
            ram_Din  <= '0;
            ram_CS_b <= 1'b1;
            ram_WE_b <= 1'b1;
            clr_busy <= 1'b0;
        end else begin
            ram_A    <= a_n;
            ram_Din  <= din_n;
            ram_CS_b <= cs_b_n;
            ram_WE_b <= we_b_n;
            clr_busy <= busy_n;
        end
    end

    // Request latch, read-nibble capture, response and pending-clear tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            lo_q       <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata;
            end
            if (state_q == LO && !we_q) lo_q <= ram_Dout;
            if (state_q == HI && !we_q) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= {ram_Dout, lo_q};
            end
            if (clr_start && (state_q == LO || state_q == HI)) clr_pend_q <= 1'b1;
            else if (state_q == IDLE && state_n == CLEAR)      clr_pend_q <= 1'b0;
        end
    end

endmodule
